// File: rtl/tlb_ctrl.sv
// TLB instruction controller: sequences SRCH/RD/WR/FILL/INV requests onto the
// TLB search, read and write ports through a three-state IDLE/EXEC/RESP FSM.
module tlb_ctrl #(
    parameter int TLBNUM = 16,
    localparam int IW = (TLBNUM > 1) ? $clog2(TLBNUM) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    // Request channel: accepted on req_valid & req_ready (IDLE only).
    // Response channel: resp_* held stable while resp_valid, consumed on resp_valid & resp_ready.
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [4:0]    inv_op,
    input  logic [9:0]    inv_asid,
    input  logic [31:0]   inv_va,
    input  logic [9:0]    csr_asid,
    input  logic [18:0]   csr_vppn,
    input  logic [IW-1:0] csr_idx,
    input  logic [5:0]    csr_ps,
    input  logic          csr_ne,
    input  logic [5:0]    csr_ecode,
    input  logic [31:0]   csr_elo0,
    input  logic [31:0]   csr_elo1,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [2:0]    resp_op,
    output logic          resp_err,
    output logic          resp_ne,
    output logic [IW-1:0] resp_idx,
    output logic [5:0]    resp_ps,
    output logic [9:0]    resp_asid,
    output logic [18:0]   resp_vppn,
    output logic [31:0]   resp_elo0,
    output logic [31:0]   resp_elo1,
    output logic          tlb_we,
    output logic [IW-1:0] tlb_w_index,
    output logic          tlb_w_e,
    output logic [18:0]   tlb_w_vppn,
    output logic [5:0]    tlb_w_ps,
    output logic [9:0]    tlb_w_asid,
    output logic          tlb_w_g,
    output logic [19:0]   tlb_w_ppn0,
    output logic [1:0]    tlb_w_plv0,
    output logic [1:0]    tlb_w_mat0,
    output logic          tlb_w_d0,
    output logic          tlb_w_v0,
    output logic [19:0]   tlb_w_ppn1,
    output logic [1:0]    tlb_w_plv1,
    output logic [1:0]    tlb_w_mat1,
    output logic          tlb_w_d1,
    output logic          tlb_w_v1,
    output logic [IW-1:0] tlb_r_index,
    input  logic          tlb_r_e,
    input  logic [18:0]   tlb_r_vppn,
    input  logic [5:0]    tlb_r_ps,
    input  logic [9:0]    tlb_r_asid,
    input  logic          tlb_r_g,
    input  logic [19:0]   tlb_r_ppn0,
    input  logic [1:0]    tlb_r_plv0,
    input  logic [1:0]    tlb_r_mat0,
    input  logic          tlb_r_d0,
    input  logic          tlb_r_v0,
    input  logic [19:0]   tlb_r_ppn1,
    input  logic [1:0]    tlb_r_plv1,
    input  logic [1:0]    tlb_r_mat1,
    input  logic          tlb_r_d1,
    input  logic          tlb_r_v1,
    output logic [18:0]   tlb_s1_vppn,
    output logic [9:0]    tlb_s1_asid,
    output logic          tlb_s1_va_bit12,
    input  logic          tlb_s1_found,
    input  logic [IW-1:0] tlb_s1_index,
    output logic          invtlb_valid,
    output logic [4:0]    invtlb_op,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    state_t          state, state_next;
    logic            accept;
    logic [IW-1:0]   fill_cnt;

    logic [2:0]      op_q;
    logic [4:0]      inv_op_q;
    logic [9:0]      inv_asid_q;
    logic [18:0]     inv_vppn_q;
    logic [9:0]      asid_q;
    logic [18:0]     vppn_q;
    logic [IW-1:0]   idx_q;
    logic [5:0]      ps_q;
    logic            ne_q;
    logic [5:0]      ecode_q;
    logic [31:0]     elo0_q;
    logic [31:0]     elo1_q;
    logic [IW-1:0]   fill_idx_q;
    logic            unused_bits;

    assign unused_bits = ^{inv_va[12:0], elo0_q[31:28], elo0_q[7], elo1_q[31:28], elo1_q[7]};

    // Ready is withheld while reset is asserted so nothing is accepted until release.
    assign req_ready       = (state == IDLE) && resetn;
    assign accept          = req_valid && req_ready;
    assign resp_valid      = (state == RESP);
    assign dbg_state       = state;
    assign tlb_s1_va_bit12 = 1'b0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                          fill_cnt <= '0;
        else if (fill_cnt == IW'(TLBNUM - 1)) fill_cnt <= '0;
        else                                  fill_cnt <= fill_cnt + IW'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q       <= '0;
            inv_op_q   <= '0;
            inv_asid_q <= '0;
            inv_vppn_q <= '0;
            asid_q     <= '0;
            vppn_q     <= '0;
            idx_q      <= '0;
            ps_q       <= '0;
            ne_q       <= 1'b0;
            ecode_q    <= '0;
            elo0_q     <= '0;
            elo1_q     <= '0;
            fill_idx_q <= '0;
        end else if (accept) begin
            op_q       <= req_op;
            inv_op_q   <= inv_op;
            inv_asid_q <= inv_asid;
            inv_vppn_q <= inv_va[31:13];
            asid_q     <= csr_asid;
            vppn_q     <= csr_vppn;
            idx_q      <= csr_idx;
            ps_q       <= csr_ps;
            ne_q       <= csr_ne;
            ecode_q    <= csr_ecode;
            elo0_q     <= csr_elo0;
            elo1_q     <= csr_elo1;
            fill_idx_q <= fill_cnt;
        end
    end

    // TLB port drive: everything is zero except during the single EXEC cycle.
    always_comb begin
        tlb_we       = 1'b0;
        tlb_w_index  = '0;
        tlb_w_e      = 1'b0;
        tlb_w_vppn   = '0;
        tlb_w_ps     = '0;
        tlb_w_asid   = '0;
        tlb_w_g      = 1'b0;
        tlb_w_ppn0   = '0;
        tlb_w_plv0   = '0;
        tlb_w_mat0   = '0;
        tlb_w_d0     = 1'b0;
        tlb_w_v0     = 1'b0;
        tlb_w_ppn1   = '0;
        tlb_w_plv1   = '0;
        tlb_w_mat1   = '0;
        tlb_w_d1     = 1'b0;
        tlb_w_v1     = 1'b0;
        tlb_r_index  = '0;
        tlb_s1_vppn  = '0;
        tlb_s1_asid  = '0;
        invtlb_valid = 1'b0;
        invtlb_op    = '0;
        if (state == EXEC) begin
            case (op_q)
                OP_SRCH: begin
                    tlb_s1_vppn = vppn_q;
                    tlb_s1_asid = asid_q;
                end
                OP_RD: tlb_r_index = idx_q;
                OP_WR, OP_FILL: begin
                    tlb_we      = 1'b1;
                    tlb_w_index = (op_q == OP_WR) ? idx_q : fill_idx_q;
                    // Ecode 0x3F marks TLB-refill context, where the entry is always made valid.
                    tlb_w_e     = (ecode_q == 6'h3F) ? 1'b1 : ~ne_q;
                    tlb_w_vppn  = vppn_q;
                    tlb_w_ps    = ps_q;
                    tlb_w_asid  = asid_q;
                    tlb_w_g     = elo0_q[6] & elo1_q[6];
                    tlb_w_ppn0  = elo0_q[27:8];
                    tlb_w_plv0  = elo0_q[3:2];
                    tlb_w_mat0  = elo0_q[5:4];
                    tlb_w_d0    = elo0_q[1];
                    tlb_w_v0    = elo0_q[0];
                    tlb_w_ppn1  = elo1_q[27:8];
                    tlb_w_plv1  = elo1_q[3:2];
                    tlb_w_mat1  = elo1_q[5:4];
                    tlb_w_d1    = elo1_q[1];
                    tlb_w_v1    = elo1_q[0];
                end
                OP_INV: begin
                    if (inv_op_q <= 5'd6) begin
                        invtlb_valid = 1'b1;
                        invtlb_op    = inv_op_q;
                        tlb_s1_vppn  = inv_vppn_q;
                        tlb_s1_asid  = inv_asid_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Results are captured on the EXEC->RESP edge and held until the next EXEC.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_op   <= '0;
            resp_err  <= 1'b0;
            resp_ne   <= 1'b0;
            resp_idx  <= '0;
            resp_ps   <= '0;
            resp_asid <= '0;
            resp_vppn <= '0;
            resp_elo0 <= '0;
            resp_elo1 <= '0;
        end else if (state == EXEC) begin
            resp_op   <= op_q;
            resp_err  <= 1'b0;
            resp_ne   <= 1'b0;
            resp_idx  <= '0;
            resp_ps   <= '0;
            resp_asid <= '0;
            resp_vppn <= '0;
            resp_elo0 <= '0;
            resp_elo1 <= '0;
            case (op_q)
                OP_SRCH: begin
                    resp_ne  <= ~tlb_s1_found;
                    resp_idx <= tlb_s1_found ? tlb_s1_index : '0;
                end
                OP_RD: begin
                    if (tlb_r_e) begin
                        resp_ps   <= tlb_r_ps;
                        resp_asid <= tlb_r_asid;
                        resp_vppn <= tlb_r_vppn;
                        resp_elo0 <= {4'h0, tlb_r_ppn0, 1'b0, tlb_r_g, tlb_r_mat0,
                                      tlb_r_plv0, tlb_r_d0, tlb_r_v0};
                        resp_elo1 <= {4'h0, tlb_r_ppn1, 1'b0, tlb_r_g, tlb_r_mat1,
                                      tlb_r_plv1, tlb_r_d1, tlb_r_v1};
                    end else begin
                        resp_ne <= 1'b1;
                    end
                end
                OP_WR, OP_FILL: ;
                OP_INV:  resp_err <= (inv_op_q > 5'd6);
                default: resp_err <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Directed bench for tlb_ctrl: a small TLB array model answers the read/search
// ports, and expected responses are queued at issue and compared at RESP.
module tb_tlb_ctrl;
    localparam int TLBNUM = 16;
    localparam int IW = 4;
    localparam int RW = 3 + 1 + 1 + IW + 6 + 10 + 19 + 32 + 32;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0, req_ready;
    logic [2:0]    req_op = '0;
    logic [4:0]    inv_op = '0;
    logic [9:0]    inv_asid = '0;
    logic [31:0]   inv_va = '0;
    logic [9:0]    csr_asid = '0;
    logic [18:0]   csr_vppn = '0;
    logic [IW-1:0] csr_idx = '0;
    logic [5:0]    csr_ps = '0;
    logic          csr_ne = 1'b0;
    logic [5:0]    csr_ecode = '0;
    logic [31:0]   csr_elo0 = '0, csr_elo1 = '0;
    logic          resp_valid, resp_ready = 1'b0;
    logic [2:0]    resp_op;
    logic          resp_err, resp_ne;
    logic [IW-1:0] resp_idx;
    logic [5:0]    resp_ps;
    logic [9:0]    resp_asid;
    logic [18:0]   resp_vppn;
    logic [31:0]   resp_elo0, resp_elo1;
    logic          tlb_we, tlb_w_e, tlb_w_g;
    logic [IW-1:0] tlb_w_index, tlb_r_index;
    logic [18:0]   tlb_w_vppn;
    logic [5:0]    tlb_w_ps;
    logic [9:0]    tlb_w_asid;
    logic [19:0]   tlb_w_ppn0, tlb_w_ppn1;
    logic [1:0]    tlb_w_plv0, tlb_w_mat0, tlb_w_plv1, tlb_w_mat1;
    logic          tlb_w_d0, tlb_w_v0, tlb_w_d1, tlb_w_v1;
    logic          tlb_r_e, tlb_r_g;
    logic [18:0]   tlb_r_vppn;
    logic [5:0]    tlb_r_ps;
    logic [9:0]    tlb_r_asid;
    logic [19:0]   tlb_r_ppn0, tlb_r_ppn1;
    logic [1:0]    tlb_r_plv0, tlb_r_mat0, tlb_r_plv1, tlb_r_mat1;
    logic          tlb_r_d0, tlb_r_v0, tlb_r_d1, tlb_r_v1;
    logic [18:0]   tlb_s1_vppn;
    logic [9:0]    tlb_s1_asid;
    logic          tlb_s1_va_bit12, tlb_s1_found;
    logic [IW-1:0] tlb_s1_index;
    logic          invtlb_valid;
    logic [4:0]    invtlb_op;
    logic [1:0]    dbg_state;

    tlb_ctrl #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
        .csr_asid(csr_asid), .csr_vppn(csr_vppn), .csr_idx(csr_idx), .csr_ps(csr_ps),
        .csr_ne(csr_ne), .csr_ecode(csr_ecode), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_op(resp_op),
        .resp_err(resp_err), .resp_ne(resp_ne), .resp_idx(resp_idx), .resp_ps(resp_ps),
        .resp_asid(resp_asid), .resp_vppn(resp_vppn), .resp_elo0(resp_elo0), .resp_elo1(resp_elo1),
        .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_e(tlb_w_e), .tlb_w_vppn(tlb_w_vppn),
        .tlb_w_ps(tlb_w_ps), .tlb_w_asid(tlb_w_asid), .tlb_w_g(tlb_w_g),
        .tlb_w_ppn0(tlb_w_ppn0), .tlb_w_plv0(tlb_w_plv0), .tlb_w_mat0(tlb_w_mat0),
        .tlb_w_d0(tlb_w_d0), .tlb_w_v0(tlb_w_v0),
        .tlb_w_ppn1(tlb_w_ppn1), .tlb_w_plv1(tlb_w_plv1), .tlb_w_mat1(tlb_w_mat1),
        .tlb_w_d1(tlb_w_d1), .tlb_w_v1(tlb_w_v1),
        .tlb_r_index(tlb_r_index), .tlb_r_e(tlb_r_e), .tlb_r_vppn(tlb_r_vppn),
        .tlb_r_ps(tlb_r_ps), .tlb_r_asid(tlb_r_asid), .tlb_r_g(tlb_r_g),
        .tlb_r_ppn0(tlb_r_ppn0), .tlb_r_plv0(tlb_r_plv0), .tlb_r_mat0(tlb_r_mat0),
        .tlb_r_d0(tlb_r_d0), .tlb_r_v0(tlb_r_v0),
        .tlb_r_ppn1(tlb_r_ppn1), .tlb_r_plv1(tlb_r_plv1), .tlb_r_mat1(tlb_r_mat1),
        .tlb_r_d1(tlb_r_d1), .tlb_r_v1(tlb_r_v1),
        .tlb_s1_vppn(tlb_s1_vppn), .tlb_s1_asid(tlb_s1_asid), .tlb_s1_va_bit12(tlb_s1_va_bit12),
        .tlb_s1_found(tlb_s1_found), .tlb_s1_index(tlb_s1_index),
        .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op), .dbg_state(dbg_state)
    );

    // TLB array model behind the write/read/search ports
    typedef struct packed {
        logic e; logic [18:0] vppn; logic [5:0] ps; logic [9:0] asid; logic g;
        logic [19:0] ppn0; logic [1:0] plv0; logic [1:0] mat0; logic d0; logic v0;
        logic [19:0] ppn1; logic [1:0] plv1; logic [1:0] mat1; logic d1; logic v1;
    } tlb_ent_t;
    tlb_ent_t tlb_mem [TLBNUM] = '{default: '0};

    always @(posedge clk)
        if (tlb_we)
            tlb_mem[tlb_w_index] <= {tlb_w_e, tlb_w_vppn, tlb_w_ps, tlb_w_asid, tlb_w_g,
                                     tlb_w_ppn0, tlb_w_plv0, tlb_w_mat0, tlb_w_d0, tlb_w_v0,
                                     tlb_w_ppn1, tlb_w_plv1, tlb_w_mat1, tlb_w_d1, tlb_w_v1};

    assign tlb_r_e    = tlb_mem[tlb_r_index].e;
    assign tlb_r_vppn = tlb_mem[tlb_r_index].vppn;
    assign tlb_r_ps   = tlb_mem[tlb_r_index].ps;
    assign tlb_r_asid = tlb_mem[tlb_r_index].asid;
    assign tlb_r_g    = tlb_mem[tlb_r_index].g;
    assign tlb_r_ppn0 = tlb_mem[tlb_r_index].ppn0;
    assign tlb_r_plv0 = tlb_mem[tlb_r_index].plv0;
    assign tlb_r_mat0 = tlb_mem[tlb_r_index].mat0;
    assign tlb_r_d0   = tlb_mem[tlb_r_index].d0;
    assign tlb_r_v0   = tlb_mem[tlb_r_index].v0;
    assign tlb_r_ppn1 = tlb_mem[tlb_r_index].ppn1;
    assign tlb_r_plv1 = tlb_mem[tlb_r_index].plv1;
    assign tlb_r_mat1 = tlb_mem[tlb_r_index].mat1;
    assign tlb_r_d1   = tlb_mem[tlb_r_index].d1;
    assign tlb_r_v1   = tlb_mem[tlb_r_index].v1;

    always_comb begin
        tlb_s1_found = 1'b0;
        tlb_s1_index = '0;
        for (int i = 0; i < TLBNUM; i++)
            if (tlb_mem[i].e && tlb_mem[i].vppn == tlb_s1_vppn &&
                (tlb_mem[i].g || tlb_mem[i].asid == tlb_s1_asid)) begin
                tlb_s1_found = 1'b1;
                tlb_s1_index = i[IW-1:0];
            end
    end

    // Free-running reference for the fill index: counts edges since reset release
    logic [31:0] model_cnt;
    always @(posedge clk or negedge resetn)
        if (!resetn) model_cnt <= '0;
        else         model_cnt <= model_cnt + 1;

    int n_checks = 0;
    int n_fail = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] resp_vec;
    logic [31:0]   acc_cnt;
    assign resp_vec = {resp_op, resp_err, resp_ne, resp_idx, resp_ps, resp_asid,
                       resp_vppn, resp_elo0, resp_elo1};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_elo(input logic [19:0] ppn, input logic g,
                                           input logic [1:0] mat, input logic [1:0] plv,
                                           input logic d, input logic v);
        return {4'h0, ppn, 1'b0, g, mat, plv, d, v};
    endfunction

    function automatic logic [RW-1:0] mk_resp(input logic [2:0] op, input logic err, input logic ne,
                                              input logic [IW-1:0] idx, input logic [5:0] ps,
                                              input logic [9:0] asid, input logic [18:0] vppn,
                                              input logic [31:0] e0, input logic [31:0] e1);
        return {op, err, ne, idx, ps, asid, vppn, e0, e1};
    endfunction

    task automatic set_csr(input logic [9:0] asid, input logic [18:0] vppn, input logic [IW-1:0] idx,
                           input logic [5:0] ps, input logic ne, input logic [5:0] ecode,
                           input logic [31:0] e0, input logic [31:0] e1);
        csr_asid = asid; csr_vppn = vppn; csr_idx = idx; csr_ps = ps;
        csr_ne = ne; csr_ecode = ecode; csr_elo0 = e0; csr_elo1 = e1;
    endtask

    // Called at posedge+1 in IDLE; returns at the negedge inside EXEC.
    task automatic issue(input logic [2:0] op);
        req_op = op;
        req_valid = 1'b1;
        @(negedge clk);
        check("req_ready_idle", req_ready, 1'b1);
        acc_cnt = model_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("no_resp_in_exec", resp_valid, 1'b0);
    endtask

    // Waits (bounded) for resp_valid, checks it against the queue head, consumes it.
    task automatic finish_resp(input string tag);
        int waited = 0;
        @(negedge clk);
        while (!resp_valid && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_latency"}, waited, 0);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: response with empty expected queue", tag);
        end else begin
            check(tag, resp_vec, exp_q.pop_front());
        end
        check({tag, "_strobes_off"}, {tlb_we, invtlb_valid}, 2'b00);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] ppn_a, ppn_b, ppn_c, ppn_d;
        logic [31:0] e5_0, e5_1, e3_0, e3_1;
        logic [3:0]  fill_w1, fill_w2;
        logic [31:0] fill_a1;
        logic        seen;
        logic [4:0]  iop;

        ppn_a = 20'($urandom_range(0, 20'hFFFFF));
        ppn_b = 20'($urandom_range(0, 20'hFFFFF));
        ppn_c = 20'($urandom_range(0, 20'hFFFFF));
        ppn_d = 20'($urandom_range(0, 20'hFFFFF));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_strobes", {tlb_we, invtlb_valid}, 2'b00);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1'b1);
        check("post_rst_resp", resp_vec, '0);
        @(posedge clk);
        #1;

        // WR index 5, both pages global
        e5_0 = mk_elo(ppn_a, 1'b1, 2'd1, 2'd3, 1'b1, 1'b1);
        e5_1 = mk_elo(ppn_b, 1'b1, 2'd2, 2'd0, 1'b0, 1'b1);
        set_csr(10'h02A, 19'h12345, 4'd5, 6'd12, 1'b0, 6'd0, e5_0, e5_1);
        exp_q.push_back(mk_resp(OP_WR, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0));
        issue(OP_WR);
        check("wr5_we", tlb_we, 1'b1);
        check("wr5_index", tlb_w_index, 4'd5);
        check("wr5_e_g", {tlb_w_e, tlb_w_g}, 2'b11);
        check("wr5_tag", {tlb_w_vppn, tlb_w_ps, tlb_w_asid}, {19'h12345, 6'd12, 10'h02A});
        check("wr5_page0", {tlb_w_ppn0, tlb_w_plv0, tlb_w_mat0, tlb_w_d0, tlb_w_v0},
              {ppn_a, 2'd3, 2'd1, 1'b1, 1'b1});
        check("wr5_page1", {tlb_w_ppn1, tlb_w_plv1, tlb_w_mat1, tlb_w_d1, tlb_w_v1},
              {ppn_b, 2'd0, 2'd2, 1'b0, 1'b1});
        check("wr5_no_inv", invtlb_valid, 1'b0);
        check("wr5_rd_srch_idle", {tlb_r_index, tlb_s1_vppn, tlb_s1_asid}, '0);
        finish_resp("wr5_resp");

        // WR index 3: NE=1 overridden by refill Ecode, G only on page 0
        e3_0 = mk_elo(ppn_c, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0);
        e3_1 = mk_elo(ppn_d, 1'b0, 2'd3, 2'd2, 1'b0, 1'b1);
        set_csr(10'h155, 19'h70F0F, 4'd3, 6'd21, 1'b1, 6'h3F, e3_0, e3_1);
        exp_q.push_back(mk_resp(OP_WR, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0));
        issue(OP_WR);
        check("wr3_index", tlb_w_index, 4'd3);
        check("wr3_e_g", {tlb_w_e, tlb_w_g}, 2'b10);
        finish_resp("wr3_resp");

        // WR index 7 with NE=1: stored invalid
        set_csr(10'h001, 19'h00777, 4'd7, 6'd12, 1'b1, 6'd0, e5_0, e5_1);
        exp_q.push_back(mk_resp(OP_WR, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0));
        issue(OP_WR);
        check("wr7_e", {tlb_we, tlb_w_e}, 2'b10);
        finish_resp("wr7_resp");

        // SRCH hit on entry 3 (non-global, asid must match)
        set_csr(10'h155, 19'h70F0F, 4'd0, 6'd0, 1'b0, 6'd0, '0, '0);
        exp_q.push_back(mk_resp(OP_SRCH, 1'b0, 1'b0, 4'd3, '0, '0, '0, '0, '0));
        issue(OP_SRCH);
        check("srch_drive", {tlb_s1_vppn, tlb_s1_asid, tlb_s1_va_bit12}, {19'h70F0F, 10'h155, 1'b0});
        check("srch_no_we", {tlb_we, invtlb_valid}, 2'b00);
        finish_resp("srch_hit3");

        // SRCH miss: asid differs on a non-global entry
        csr_asid = 10'h154;
        exp_q.push_back(mk_resp(OP_SRCH, 1'b0, 1'b1, 4'd0, '0, '0, '0, '0, '0));
        issue(OP_SRCH);
        finish_resp("srch_miss");

        // SRCH hit on global entry 5 with unrelated asid
        set_csr(10'h3FF, 19'h12345, 4'd0, 6'd0, 1'b0, 6'd0, '0, '0);
        exp_q.push_back(mk_resp(OP_SRCH, 1'b0, 1'b0, 4'd5, '0, '0, '0, '0, '0));
        issue(OP_SRCH);
        finish_resp("srch_hit5_global");

        // RD entry 5
        csr_idx = 4'd5;
        exp_q.push_back(mk_resp(OP_RD, 1'b0, 1'b0, '0, 6'd12, 10'h02A, 19'h12345, e5_0, e5_1));
        issue(OP_RD);
        check("rd5_index", tlb_r_index, 4'd5);
        finish_resp("rd5_resp");

        // RD entry 3: G read back as elo0.G & elo1.G = 0 on both pages
        csr_idx = 4'd3;
        exp_q.push_back(mk_resp(OP_RD, 1'b0, 1'b0, '0, 6'd21, 10'h155, 19'h70F0F,
                                mk_elo(ppn_c, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0),
                                mk_elo(ppn_d, 1'b0, 2'd3, 2'd2, 1'b0, 1'b1)));
        issue(OP_RD);
        finish_resp("rd3_resp");

        // RD entry 7 (invalid): NE=1 and everything else zero
        csr_idx = 4'd7;
        exp_q.push_back(mk_resp(OP_RD, 1'b0, 1'b1, '0, '0, '0, '0, '0, '0));
        issue(OP_RD);
        finish_resp("rd7_resp");

        // INV legal/illegal sub-ops, including the 6/7 boundary
        inv_va = 32'hDEAD_B123;
        inv_asid = 10'h3C1;
        for (int k = 0; k < 4; k++) begin
            iop = (k == 0) ? 5'd5 : (k == 1) ? 5'd9 : (k == 2) ? 5'd6 : 5'd7;
            inv_op = iop;
            exp_q.push_back(mk_resp(OP_INV, iop > 5'd6, 1'b0, '0, '0, '0, '0, '0, '0));
            issue(OP_INV);
            if (iop <= 5'd6) begin
                check("inv_pulse", {invtlb_valid, invtlb_op}, {1'b1, iop});
                check("inv_s1", {tlb_s1_vppn, tlb_s1_asid}, {inv_va[31:13], 10'h3C1});
            end else begin
                check("inv_illegal_quiet", {invtlb_valid, invtlb_op, tlb_s1_vppn}, '0);
            end
            check("inv_no_we", tlb_we, 1'b0);
            finish_resp("inv_resp");
        end

        // Illegal req_op values
        for (int k = 5; k < 8; k++) begin
            exp_q.push_back(mk_resp(3'(k), 1'b1, 1'b0, '0, '0, '0, '0, '0, '0));
            issue(3'(k));
            check("illegal_no_strobe", {tlb_we, invtlb_valid}, 2'b00);
            finish_resp("illegal_resp");
        end

        // FILL twice, 20 idle cycles apart
        set_csr(10'h0AA, 19'h55555, 4'd0, 6'd14, 1'b0, 6'd0, e5_0, e3_1);
        exp_q.push_back(mk_resp(OP_FILL, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0));
        issue(OP_FILL);
        fill_a1 = acc_cnt;
        fill_w1 = tlb_w_index;
        check("fill1_index", {tlb_we, tlb_w_index}, {1'b1, acc_cnt[3:0]});
        check("fill1_g", tlb_w_g, 1'b0);
        finish_resp("fill1_resp");
        repeat (20) @(posedge clk);
        #1;
        exp_q.push_back(mk_resp(OP_FILL, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0));
        issue(OP_FILL);
        fill_w2 = tlb_w_index;
        check("fill2_index", {tlb_we, tlb_w_index}, {1'b1, acc_cnt[3:0]});
        check("fill_delta", 4'(fill_w2 - fill_w1), 4'(acc_cnt - fill_a1));
        finish_resp("fill2_resp");

        // FILL landing on index 15, then another that wraps past 0
        for (int k = 0; k < 17 && model_cnt[3:0] != 4'hF; k++) begin
            @(posedge clk);
            #1;
        end
        exp_q.push_back(mk_resp(OP_FILL, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0));
        issue(OP_FILL);
        check("fill_index15", tlb_w_index, 4'd15);
        finish_resp("fill15_resp");
        exp_q.push_back(mk_resp(OP_FILL, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0));
        issue(OP_FILL);
        check("fill_wrap", tlb_w_index, 4'd2);
        finish_resp("fill_wrap_resp");

        // Response back-pressure: 10 cycles with resp_ready low
        csr_idx = 4'd5;
        exp_q.push_back(mk_resp(OP_RD, 1'b0, 1'b0, '0, 6'd12, 10'h02A, 19'h12345, e5_0, e5_1));
        issue(OP_RD);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_hold", {resp_valid, req_ready, resp_vec}, {1'b1, 1'b0, exp_q[0]});
        end
        finish_resp("stall_resp");

        // Reset pulse during EXEC of a WR to entry 9: no write, no response
        set_csr(10'h011, 19'h00999, 4'd9, 6'd12, 1'b0, 6'd0, e5_0, e5_1);
        req_op = OP_WR;
        req_valid = 1'b1;
        @(posedge clk);
        #1 resetn = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_exec_quiet", {tlb_we, resp_valid, req_ready}, 3'b000);
        @(posedge clk);
        #1 resetn = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid || tlb_we) seen = 1'b1;
        end
        check("rst_exec_no_resp", seen, 1'b0);
        @(posedge clk);
        #1;
        exp_q.push_back(mk_resp(OP_RD, 1'b0, 1'b1, '0, '0, '0, '0, '0, '0));
        issue(OP_RD);
        finish_resp("rd9_not_written");

        // Reset pulse during RESP of a RD: response dropped and cleared
        csr_idx = 4'd5;
        issue(OP_RD);
        @(negedge clk);
        check("rst_resp_valid_before", resp_valid, 1'b1);
        resetn = 1'b0;
        #1;
        check("rst_resp_cleared", {resp_valid, resp_vec}, '0);
        @(posedge clk);
        #1 resetn = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid || tlb_we || invtlb_valid) seen = 1'b1;
        end
        check("rst_resp_no_resp", seen, 1'b0);
        @(posedge clk);
        #1;

        // Normal operation after the aborts
        set_csr(10'h155, 19'h70F0F, 4'd0, 6'd0, 1'b0, 6'd0, '0, '0);
        exp_q.push_back(mk_resp(OP_SRCH, 1'b0, 1'b0, 4'd3, '0, '0, '0, '0, '0));
        issue(OP_SRCH);
        finish_resp("srch_after_reset");

        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tlb_ctrl.md
TLB_CTRL -- requirements
Module: tlb_ctrl

Interface
REQ-001 The block SHALL have parameter TLBNUM, default 16, the number of TLB entries; index width is IW = clog2(TLBNUM).
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  TLB-instruction request.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_op  in  3  0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV; 5-7 illegal.
- inv_op  in  5  INVTLB op code.
- inv_asid  in  10  INVTLB asid operand.
- inv_va  in  32  INVTLB va operand.
- csr_asid  in  10  ASID.ASID.
- csr_vppn  in  19  TLBEHI.VPPN.
- csr_idx  in  IW  TLBIDX.Index.
- csr_ps  in  6  TLBIDX.PS.
- csr_ne  in  1  TLBIDX.NE.
- csr_ecode  in  6  ESTAT.Ecode.
- csr_elo0, csr_elo1  in  32 each  TLBELO0/1: V[0] D[1] PLV[3:2] MAT[5:4] G[6] PPN[27:8].
- resp_valid  out  1  result valid.
- resp_ready  in  1  result consumed.
- resp_op  out  3  echoed req_op.
- resp_err  out  1  illegal req_op or inv_op.
- resp_ne, resp_idx, resp_ps, resp_asid, resp_vppn  out  1/IW/6/10/19  SRCH/RD results.
- resp_elo0, resp_elo1  out  32 each  RD results, same layout as csr_elo.
- tlb_we  out  1  TLB write strobe.
- tlb_w_index  out  IW  write index.
- tlb_w_e, tlb_w_vppn, tlb_w_ps, tlb_w_asid, tlb_w_g  out  1/19/6/10/1  write tag fields.
- tlb_w_ppn0/plv0/mat0/d0/v0  out  20/2/2/1/1  even page; tlb_w_*1 likewise for the odd page.
- tlb_r_index  out  IW  read index.
- tlb_r_*  in  -  read-port returns: e, vppn, ps, asid, g, ppn0/1, plv0/1, mat0/1, d0/1, v0/1.
- tlb_s1_vppn, tlb_s1_asid, tlb_s1_va_bit12  out  19/10/1  search port 1 drive.
- tlb_s1_found, tlb_s1_index  in  1/IW  search result.
- invtlb_valid, invtlb_op  out  1/5  invalidate strobe and op.

Function
REQ-003 The FSM SHALL have three states: IDLE, EXEC, RESP; req_ready = 1 only in IDLE.
REQ-004 On handshake in IDLE: latch op, all operands and all CSR inputs; go to EXEC.
REQ-005 EXEC SHALL last exactly one cycle, then go to RESP; resp_valid is asserted two cycles after the accept edge.
REQ-006 RESP SHALL hold resp_valid and all resp_* stable until resp_valid & resp_ready, then return to IDLE; a new accept is possible the cycle after.
REQ-007 tlb_we and invtlb_valid SHALL be single-cycle pulses, asserted only in EXEC, and never together.
REQ-008 WR: tlb_we=1 with tlb_w_index = latched csr_idx.
REQ-009 FILL: tlb_we=1 with tlb_w_index = a free-running IW-bit counter sampled at accept; the counter increments every cycle and wraps TLBNUM-1 -> 0.
REQ-010 WR/FILL fields:
- tlb_w_e = 1 if csr_ecode == 6'h3F, else ~csr_ne.
- tlb_w_g = elo0.G & elo1.G.
- vppn = csr_vppn, ps = csr_ps, asid = csr_asid.
- Per-page fields come from the matching elo.
REQ-011 SRCH: drive s1_vppn = csr_vppn and s1_asid = csr_asid in EXEC, and capture the result at the end of EXEC:
- found: resp_ne = 0, resp_idx = s1_index.
- not found: resp_ne = 1, resp_idx = 0.
REQ-012 RD: drive tlb_r_index = csr_idx in EXEC.
- r_e = 1: resp_ne = 0; capture ps/asid/vppn; pack elo fields with G = r_g in both elo registers.
- r_e = 0: resp_ne = 1 and all other resp fields 0.
REQ-013 INV with inv_op <= 6: invtlb_valid = 1, invtlb_op = inv_op, s1_vppn = inv_va[31:13], s1_asid = inv_asid.
REQ-014 INV with inv_op > 6: no invtlb_valid; resp_err = 1.
REQ-015 req_op 5-7: no TLB strobe; resp_err = 1; all other resp fields 0.
REQ-016 Outside EXEC, all s1_*, r_index and w_* outputs SHALL be 0; s1_va_bit12 SHALL always be 0.

Reset
REQ-017 When resetn = 0, the block SHALL immediately enter IDLE and clear the fill counter and all resp_* outputs; tlb_we, invtlb_valid and resp_valid go to 0, and req_ready goes to 1 once resetn = 1.
REQ-018 Reset asserted during EXEC or RESP SHALL abort the operation: no strobe pulses, and no resp_valid after release.

Verification
REQ-019 WR: csr_idx=5, ne=0, elo0.G=elo1.G=1 -> tlb_we for one cycle at accept+1, w_index=5, w_e=1, w_g=1; resp_valid at accept+2.
REQ-020 SRCH hit: TLB entry 3 matches vppn/asid -> resp_ne=0, resp_idx=3. Miss -> resp_ne=1, resp_idx=0.
REQ-021 FILL twice with 20 idle cycles between -> write indices differ by (cycles between accepts) mod 16; index 15 wraps to 0.
REQ-022 INV op 5, then op 9 -> first produces invtlb_valid pulse with op 5 and s1_vppn=inv_va[31:13]; second produces no pulse and resp_err=1.
REQ-023 resp_ready held low 10 cycles -> resp_* stable and req_ready=0 throughout; resetn pulsed low in EXEC -> no tlb_we, no resp_valid.
